// File: rtl/serial_adder_sub_if.sv
// serial_adder_sub_if: operand/result handshake bundle for the serial adder/subtractor
interface serial_adder_sub_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic             out_valid;
   logic             out_ready;
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, s, cout, ovf, out_valid
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, s, cout, ovf, out_valid
   );
endinterface

// File: rtl/serial_adder_sub.sv
// serial_adder_sub: multi-cycle add/subtract, DIGIT bits per cycle LSB-first with registered carry
module serial_adder_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic clk,
   input logic rst,
   serial_adder_sub_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state, state_nx;
   logic [WIDTH-1:0] a_r, b_r, res_r, res_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   slice_sum;
   logic             last;
   int               idx;
   if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_params
      $error("serial_adder_sub: WIDTH must be a positive multiple of DIGIT");
   end
   assign bus.in_ready  = state == IDLE;
   assign bus.out_valid = state == DONE;
   // current digit slice sum; cnt is returned to 0 on leaving RUN so idx never points past the operands
   always_comb begin
      idx       = int'(cnt) * DIGIT;
      slice_sum = {1'b0, a_r[idx +: DIGIT]} + {1'b0, b_r[idx +: DIGIT]} + {{DIGIT{1'b0}}, carry};
      res_nx    = res_r;
      res_nx[idx +: DIGIT] = slice_sum[DIGIT-1:0];
      last      = cnt == CW'(N - 1);
   end
   // next-state: accept in IDLE, N digit cycles in RUN, hold in DONE until consumed
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE) :
                 state == RUN  ? (last ? DONE : RUN) :
                 (bus.out_ready ? IDLE : DONE);
   end
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   // operand latch, digit datapath and result registers; subtraction is A + ~B + ~borrow
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r      <= '0;
         b_r      <= '0;
         res_r    <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         bus.s    <= '0;
         bus.cout <= 1'b0;
         bus.ovf  <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         a_r   <= bus.a;
         b_r   <= bus.b ^ {WIDTH{bus.sub}};
         carry <= bus.cin ^ bus.sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         res_r <= res_nx;
         carry <= slice_sum[DIGIT];
         cnt   <= last ? '0 : cnt + 1'b1;
         if (last) begin
            bus.s    <= res_nx;
            bus.cout <= slice_sum[DIGIT];
            bus.ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (res_nx[WIDTH-1] != a_r[WIDTH-1]);
         end
      end
   end
endmodule
